register_file_param: RTL and testbench
======================================

// Module: register_file_param
// PURPOSE
//   Parametrised 2-read/1-write register file; next generation of the team's register file.
//   Configurable width and depth, optional hard-wired zero register, byte-strobed writes.
//   Registered reads with a valid flag replace the tristated read outputs.
//   Optional write-to-read bypass and synchronous clear.
//   Sits between decode (addresses) and the execute datapath.
// PARAMETERS
//   DATA_WIDTH  32  register width in bits; multiple of 8
//   ADDR_WIDTH  5   address bits; DEPTH = 2**ADDR_WIDTH registers
//   ZERO_REG    1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//   BYPASS      1   1: same-cycle write data forwarded to reads; 0: reads return pre-write contents
// PORTS
//   clk          in   1             rising-edge clock
//   reset        in   1             asynchronous, active-high reset
//   read_enable  in   1             capture both read ports this cycle
//   out_addr_1   in   ADDR_WIDTH    read port 1 address
//   out_addr_2   in   ADDR_WIDTH    read port 2 address
//   out_data_1   out  DATA_WIDTH    registered read data, port 1
//   out_data_2   out  DATA_WIDTH    registered read data, port 2
//   out_valid    out  1             out_data_1/2 hold data from the read issued last cycle
//   write_enable in   1             write in_data to in_addr at the clock edge
//   in_addr      in   ADDR_WIDTH    write address
//   in_data      in   DATA_WIDTH    write data
//   in_strb      in   DATA_WIDTH/8  byte write strobes; bit k enables in_data[8k+7:8k]
//   clear        in   1             synchronous clear of all registers
// BEHAVIOUR
//   Reset (async, reset=1): all registers 0; out_data_1/2 = 0; out_valid = 0. Held while reset=1.
//   Write: on posedge with write_enable=1, update the bytes of reg[in_addr] whose in_strb bit is 1.
//     - Bytes with strobe 0 keep their value. in_strb=0 makes the write a no-op.
//     - ZERO_REG=1 and in_addr=0: write discarded.
//   Read: on posedge with read_enable=1:
//     - out_data_n <= rd(out_addr_n); out_valid <= 1.
//     - Latency: data is visible 1 cycle after the address is presented.
//   Read disabled: with read_enable=0, out_data_n hold their last value (never Z); out_valid <= 0.
//   rd(a) function:
//     - 0 if ZERO_REG=1 and a=0.
//     - Otherwise, if BYPASS=1, write_enable=1 and in_addr=a: reg[a] with strobed bytes replaced
//       by in_data, i.e. identical to the post-write contents. Both ports bypass independently.
//     - Otherwise reg[a] (pre-edge contents).
//   Clear: on posedge with clear=1, all registers <= 0.
//     - Clear overrides a same-cycle write; the write is lost.
//     - A same-cycle read returns pre-clear data (or bypass data if BYPASS=1 and write matches),
//       and out_valid <= 1 if read_enable=1. out_data is not cleared by clear.
//   Simultaneous events:
//     - Both read ports on the same address: both get the same value.
//     - reset has priority over everything.
//     - Reset asserted mid-operation: the pending read is discarded and out_valid drops to 0
//       asynchronously.
//   Addresses are always in range (DEPTH = 2**ADDR_WIDTH); no out-of-range handling.
// TESTING
//   1. Reset mid-run: write reg3=0xDEADBEEF, assert reset asynchronously between edges
//      -> out_valid=0, out_data=0 at once; reading reg3 afterwards gives 0.
//   2. Write reg5=0x12345678, next cycle read port1=5, port2=0 (ZERO_REG=1)
//      -> one cycle later out_data_1=0x12345678, out_data_2=0, out_valid=1.
//   3. Write reg0=0xFFFFFFFF with ZERO_REG=1, then read 0 -> 0.
//      Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
//   4. reg7=0xAABBCCDD; write in_data=0x11223344, in_strb=4'b0101 to reg7
//      -> reg7 reads 0xAA22CC44.
//   5. Bypass: reg9=0x1; same cycle write reg9=0x2 and read port1=9, port2=9
//      -> BYPASS=1: both outputs 0x2; BYPASS=0: both 0x1, then 0x2 on the next read.
//   6. Clear + write reg4=0x5 same cycle -> reg4 reads 0.
//      read_enable low for 3 cycles -> out_data held, out_valid=0.

Source files
------------

// File: rtl/register_file_param.sv
// Parametrised 2-read/1-write register file.
// Byte-strobed writes, registered reads, optional zero reg and bypass.
module register_file_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_enable,
  input  logic [ADDR_WIDTH-1:0]   out_addr_1,
  input  logic [ADDR_WIDTH-1:0]   out_addr_2,
  output logic [DATA_WIDTH-1:0]   out_data_1,
  output logic [DATA_WIDTH-1:0]   out_data_2,
  output logic                    out_valid,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_strb,
  input  logic                    clear
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_1;
  logic [DATA_WIDTH-1:0] rd_2;
  logic                  wr_ok;

  // Post-write image of the addressed register; shared by write and bypass.
  always_comb begin
    wr_merged = regs[in_addr];
    for (int k = 0; k < NB; k++) begin
      if (in_strb[k]) begin
        wr_merged[8*k +: 8] = in_data[8*k +: 8];
      end
    end
  end

  assign wr_ok = write_enable &&
                 !(ZERO_REG && (in_addr == '0));

  always_comb begin
    rd_1 = regs[out_addr_1];
    if (BYPASS && write_enable &&
        (in_addr == out_addr_1)) begin
      rd_1 = wr_merged;
    end
    if (ZERO_REG && (out_addr_1 == '0)) begin
      rd_1 = '0;
    end
  end

  always_comb begin
    rd_2 = regs[out_addr_2];
    if (BYPASS && write_enable &&
        (in_addr == out_addr_2)) begin
      rd_2 = wr_merged;
    end
    if (ZERO_REG && (out_addr_2 == '0)) begin
      rd_2 = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[in_addr] <= wr_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_1 <= '0;
      out_data_2 <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= read_enable;
      if (read_enable) begin
        out_data_1 <= rd_1;
        out_data_2 <= rd_2;
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param.
// Default DUT (zero reg, bypass) alongside a plain variant.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_enable;
  logic [4:0]  out_addr_1;
  logic [4:0]  out_addr_2;
  logic        write_enable;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_strb;
  logic        clear;

  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_v, b_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_param u_a (
    .clk(clk), .reset(reset),
    .read_enable(read_enable),
    .out_addr_1(out_addr_1), .out_addr_2(out_addr_2),
    .out_data_1(a_d1), .out_data_2(a_d2),
    .out_valid(a_v),
    .write_enable(write_enable), .in_addr(in_addr),
    .in_data(in_data), .in_strb(in_strb),
    .clear(clear)
  );

  register_file_param #(
    .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) u_b (
    .clk(clk), .reset(reset),
    .read_enable(read_enable),
    .out_addr_1(out_addr_1), .out_addr_2(out_addr_2),
    .out_data_1(b_d1), .out_data_2(b_d2),
    .out_valid(b_v),
    .write_enable(write_enable), .in_addr(in_addr),
    .in_data(in_data), .in_strb(in_strb),
    .clear(clear)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    write_enable = 1'b1;
    in_addr = a;
    in_data = d;
    in_strb = s;
    read_enable = 1'b0;
    step();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1,
                    input logic [4:0] a2);
    read_enable = 1'b1;
    out_addr_1 = a1;
    out_addr_2 = a2;
    step();
    read_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    read_enable = 1'b0;
    out_addr_1 = '0;
    out_addr_2 = '0;
    write_enable = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_strb = '0;
    clear = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, a_v}, 32'd0);
    chk("rst_d1", a_d1, 32'd0);
    chk("rst_d2", a_d2, 32'd0);
    reset = 1'b0;
    step();

    // write then read, zero reg on port 2
    wr(5'd5, 32'h1234_5678, 4'hF);
    rd(5'd5, 5'd0);
    chk("rd5_a_d1", a_d1, 32'h1234_5678);
    chk("rd0_a_d2", a_d2, 32'h0);
    chk("rd_a_valid", {31'd0, a_v}, 32'd1);
    chk("rd5_b_d1", b_d1, 32'h1234_5678);

    // writes to reg0
    wr(5'd0, 32'hFFFF_FFFF, 4'hF);
    rd(5'd0, 5'd0);
    chk("zero_a", a_d1, 32'h0);
    chk("zero_b", b_d1, 32'hFFFF_FFFF);
    chk("zero_b2", b_d2, 32'hFFFF_FFFF);

    // byte strobes
    wr(5'd7, 32'hAABB_CCDD, 4'hF);
    wr(5'd7, 32'h1122_3344, 4'b0101);
    rd(5'd7, 5'd7);
    chk("strb_a", a_d1, 32'hAA22_CC44);
    chk("strb_b", b_d2, 32'hAA22_CC44);
    wr(5'd7, 32'hFFFF_FFFF, 4'h0);
    rd(5'd7, 5'd5);
    chk("strb0_a", a_d1, 32'hAA22_CC44);
    chk("strb0_a2", a_d2, 32'h1234_5678);

    // read disabled: hold data, drop valid
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_d1", a_d1, 32'hAA22_CC44);
      chk("hold_d2", a_d2, 32'h1234_5678);
      chk("hold_v", {31'd0, a_v}, 32'd0);
    end

    // same-cycle write and read
    wr(5'd9, 32'h1, 4'hF);
    write_enable = 1'b1;
    in_addr = 5'd9;
    in_data = 32'h2;
    in_strb = 4'hF;
    rd(5'd9, 5'd9);
    write_enable = 1'b0;
    chk("byp_a1", a_d1, 32'h2);
    chk("byp_a2", a_d2, 32'h2);
    chk("nobyp_b1", b_d1, 32'h1);
    chk("nobyp_b2", b_d2, 32'h1);
    rd(5'd9, 5'd9);
    chk("after_b1", b_d1, 32'h2);

    // clear with same-cycle write and read
    wr(5'd4, 32'h77, 4'hF);
    clear = 1'b1;
    write_enable = 1'b1;
    in_addr = 5'd4;
    in_data = 32'h5;
    in_strb = 4'hF;
    rd(5'd4, 5'd5);
    clear = 1'b0;
    write_enable = 1'b0;
    chk("clr_a1", a_d1, 32'h5);
    chk("clr_a2", a_d2, 32'h1234_5678);
    chk("clr_b1", b_d1, 32'h77);
    chk("clr_v", {31'd0, a_v}, 32'd1);
    rd(5'd4, 5'd5);
    chk("post_clr_a1", a_d1, 32'h0);
    chk("post_clr_a2", a_d2, 32'h0);
    chk("post_clr_b1", b_d1, 32'h0);

    // asynchronous reset mid-run
    wr(5'd3, 32'hDEAD_BEEF, 4'hF);
    rd(5'd3, 5'd3);
    chk("pre_rst", a_d1, 32'hDEAD_BEEF);
    read_enable = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_v", {31'd0, a_v}, 32'd0);
    chk("arst_d1", a_d1, 32'h0);
    chk("arst_d2", a_d2, 32'h0);
    step();
    chk("arst_hold", {31'd0, a_v}, 32'd0);
    reset = 1'b0;
    rd(5'd3, 5'd3);
    chk("rst_rd3", a_d1, 32'h0);
    chk("rst_rd3_b", b_d2, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
